sum_window_avg: RTL and testbench
=================================

Name: sum_window_avg

Overview:
- Downstream consumer of the registered two-operand adder. Takes its 8-bit sum stream through a valid/ready input.
- Accumulates windows of 2^N_LOG2 samples. Per window it produces the total sum, a rounded average, the maximum and the minimum.
- Results go out through a valid/ready output with a hold stage, so the next stage can stall without losing a result.

Parameters:
- IN_W, 8, sample width; matches the adder output width.
- N_LOG2, 2, log2 of window length. N = 2^N_LOG2 = 4 by default. Legal range 0..6.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- clr  input  1  synchronous window abort/restart
- in_valid  input  1  sample present on in_data
- in_data  input  IN_W  sample (adder sum)
- in_ready  output  1  block accepts a sample this cycle
- out_valid  output  1  window result available
- out_ready  input  1  downstream accepts result
- out_sum  output  IN_W+N_LOG2  window total
- out_avg  output  IN_W  rounded mean
- out_max  output  IN_W  largest sample in window
- out_min  output  IN_W  smallest sample in window

Behaviour:
- One clock domain (clk). rst_n is asynchronous, active-low; deassertion is synchronised externally.
- FSM has two states:
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- in_ready and out_valid are decoded combinationally from the state register only. There is no combinational path from in_valid or out_ready.
- Reset values:
  - state=ACCUM, so in_ready=1 from reset onward.
  - count=0, acc=0, run_max=0, run_min=all-ones.
  - out_valid=0, out_sum=0, out_avg=0, out_max=0, out_min=0.
- Accept: in_valid && in_ready in ACCUM. On an accept:
  - acc += in_data, at width IN_W+N_LOG2; it cannot overflow.
  - count++.
  - run_max and run_min update with unsigned compares; ties keep the existing value.
- Window complete: an accept when count==N-1. At that clock edge:
  - out_sum <= acc+in_data.
  - out_max and out_min <= the final tracker values, including this sample.
  - out_avg <= (final_sum + 2^(N_LOG2-1)) >> N_LOG2, round half up. Computed at width IN_W+N_LOG2+1; the result always fits IN_W (all-max input gives the max value). For N_LOG2=0, out_avg = out_sum.
  - state <= HOLD; acc, count and trackers reinitialise.
- Latency: out_valid asserts the cycle after the Nth accept.
- HOLD:
  - in_valid is ignored.
  - Outputs are stable while out_valid && !out_ready.
  - When out_ready=1, state <= ACCUM on that edge. The earliest next accept is the following cycle.
  - Throughput with no stall: N samples per N+1 cycles.
- clr=1 (priority over all except reset):
  - state <= ACCUM; count, acc and trackers reinitialise; out_valid drops next cycle.
  - A pending HOLD result is discarded. A sample presented with clr=1 is discarded.
  - out_* data registers keep their last values.
- rst_n asserted mid-window or in HOLD: immediate return to reset values. Partial windows are lost.
- in_valid with an X in_data while in HOLD must not corrupt state.

Decomposition:
- Package sum_window_pkg holds:
  - the state enum (ACCUM, HOLD);
  - localparams for accumulator width (IN_W+N_LOG2) and rounding constant;
  - the window-length function.
- One sub-module is natural: minmax_tracker. It holds the running unsigned max/min registers with init/update controls and the parameter IN_W.
- The counter, accumulator, rounding and FSM stay in the top.

Test Plan:
- Reset, then N=4 samples 10,20,30,41 with out_ready=1 -> out_valid high one cycle after the 4th accept; out_sum=101, out_avg=25, out_max=41, out_min=10; in_ready returns to 1 the next cycle.
- Four samples of 255 -> out_sum=1020, out_avg=255, out_max=out_min=255. Four samples of 0 -> all outputs 0.
- Complete a window with out_ready=0 held 5 cycles and in_valid=1 throughout -> in_ready=0 and outputs constant for all 5 cycles; no sample absorbed. Raise out_ready -> result consumed; the next window starts with count=0.
- Accept 7 and 9, pulse clr, then feed 1,2,3,4 -> out_sum=10, out_avg=3, out_max=4, out_min=1. Earlier samples have no effect.
- Complete a window, assert rst_n=0 during HOLD -> out_valid=0 and outputs 0 immediately (asynchronous). After release, in_ready=1 and a fresh window of 2,2,2,3 -> out_sum=9, out_avg=2.
- Continuous in_valid=1, out_ready=1 for 20 cycles with ramp data 0..19 -> 4 results, each asserted on every 5th cycle. Sums 6, 26, 46, 66, taken from samples accepted in ACCUM only; averages 2, 7, 12, 17.

Source files
------------

// File: rtl/sum_window_pkg.sv
// sum_window_pkg: shared state type and sizing helpers for the window averager
package sum_window_pkg;

    typedef enum logic {ACCUM, HOLD} state_t;

    localparam int DEF_IN_W   = 8;
    localparam int DEF_N_LOG2 = 2;
    localparam int DEF_ACC_W  = DEF_IN_W + DEF_N_LOG2;
    localparam int DEF_RND    = 1 << (DEF_N_LOG2 - 1);

    function automatic int win_len(input int n_log2);
        return 1 << n_log2;
    endfunction

    function automatic int acc_width(input int in_w, input int n_log2);
        return in_w + n_log2;
    endfunction

    // Half of the window length; zero for a single-sample window so the mean is the sample itself
    function automatic int round_const(input int n_log2);
        return (n_log2 == 0) ? 0 : (1 << (n_log2 - 1));
    endfunction

endpackage

// File: rtl/sum_window_avg_minmax_tracker.sv
// minmax_tracker: running unsigned max/min with restart and per-sample update
module minmax_tracker #(
    parameter int IN_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_init,
    input  logic            i_upd,
    input  logic [IN_W-1:0] i_data,
    output logic [IN_W-1:0] o_nmax,
    output logic [IN_W-1:0] o_nmin
);
    logic [IN_W-1:0] r_max;
    logic [IN_W-1:0] r_min;

    // Ties keep the stored value, so only a strictly larger/smaller sample replaces it
    always_comb begin
        o_nmax = (i_data > r_max) ? i_data : r_max;
        o_nmin = (i_data < r_min) ? i_data : r_min;
    end

    // Restart wins over update so a completing or aborted window leaves fresh trackers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_max <= '0;
            r_min <= '1;
        end else if (i_init) begin
            r_max <= '0;
            r_min <= '1;
        end else if (i_upd) begin
            r_max <= o_nmax;
            r_min <= o_nmin;
        end
    end
endmodule

// File: rtl/sum_window_avg.sv
// sum_window_avg: per-window sum, rounded mean, max and min of an 8-bit sample stream
module sum_window_avg
    import sum_window_pkg::*;
#(
    parameter int IN_W   = 8,
    parameter int N_LOG2 = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   in_valid,
    input  logic [IN_W-1:0]        in_data,
    output logic                   in_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [IN_W+N_LOG2-1:0] out_sum,
    output logic [IN_W-1:0]        out_avg,
    output logic [IN_W-1:0]        out_max,
    output logic [IN_W-1:0]        out_min
);
    localparam int N     = win_len(N_LOG2);
    localparam int ACC_W = acc_width(IN_W, N_LOG2);
    localparam int RND   = round_const(N_LOG2);
    localparam int CW    = N_LOG2 + 1;

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   r_sum;
    logic [IN_W-1:0]    r_avg;
    logic [IN_W-1:0]    r_max;
    logic [IN_W-1:0]    r_min;
    logic               w_acc;
    logic               w_done;
    logic [ACC_W-1:0]   w_sum;
    logic [ACC_W:0]     w_rnd;
    logic [IN_W-1:0]    w_avg;
    logic [IN_W-1:0]    w_nmax;
    logic [IN_W-1:0]    w_nmin;

    // Handshake decoded from state only; window arithmetic on the incoming sample
    always_comb begin
        in_ready  = (r_state == ACCUM);
        out_valid = (r_state == HOLD);
        w_acc     = in_valid && in_ready;
        w_done    = w_acc && (r_cnt == CW'(N - 1));
        w_sum     = r_acc + ACC_W'(in_data);
        w_rnd     = {1'b0, w_sum} + (ACC_W + 1)'(RND);
        w_avg     = IN_W'(w_rnd >> N_LOG2);
    end

    assign out_sum = r_sum;
    assign out_avg = r_avg;
    assign out_max = r_max;
    assign out_min = r_min;

    minmax_tracker #(.IN_W(IN_W)) u_trk (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_init (clr || w_done),
        .i_upd  (w_acc && !clr),
        .i_data (in_data),
        .o_nmax (w_nmax),
        .o_nmin (w_nmin)
    );

    // Window FSM: accumulate N samples, publish into the hold registers, wait for consumer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ACCUM;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_avg   <= '0;
            r_max   <= '0;
            r_min   <= '0;
        end else if (clr) begin
            r_state <= ACCUM;
            r_cnt   <= '0;
            r_acc   <= '0;
        end else if (r_state == ACCUM) begin
            if (w_done) begin
                r_state <= HOLD;
                r_cnt   <= '0;
                r_acc   <= '0;
                r_sum   <= w_sum;
                r_avg   <= w_avg;
                r_max   <= w_nmax;
                r_min   <= w_nmin;
            end else if (w_acc) begin
                r_cnt   <= r_cnt + CW'(1);
                r_acc   <= w_sum;
            end
        end else if (out_ready) begin
            r_state <= ACCUM;
        end
    end
endmodule

// File: tb/tb_sum_window_avg.sv
// tb_sum_window_avg: scoreboard bench for the window sum/avg/max/min block
module tb_sum_window_avg;
    typedef struct packed {
        logic [9:0] s;
        logic [7:0] a;
        logic [7:0] mx;
        logic [7:0] mn;
    } res_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] out_sum;
    logic [7:0] out_avg;
    logic [7:0] out_max;
    logic [7:0] out_min;
    res_t       obs;

    res_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   m_cnt, m_acc, m_max, m_min;
    bit   m_hold;

    sum_window_avg #(.IN_W(8), .N_LOG2(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_avg   (out_avg),
        .out_max   (out_max),
        .out_min   (out_min)
    );

    assign obs = {out_sum, out_avg, out_max, out_min};

    always #5 clk = ~clk;

    task automatic m_init();
        m_cnt = 0;
        m_acc = 0;
        m_max = 0;
        m_min = 255;
    endtask

    // Drive one cycle, advance the reference model, leave time 1 unit after the edge
    task automatic drive(input bit v, input logic [7:0] d, input bit r, input bit c);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        clr       = c;
        @(posedge clk);
        if (c) begin
            m_hold = 0;
            m_init();
        end else if (m_hold) begin
            if (r) m_hold = 0;
        end else if (v) begin
            m_acc = m_acc + int'(d);
            if (int'(d) > m_max) m_max = int'(d);
            if (int'(d) < m_min) m_min = int'(d);
            m_cnt++;
            if (m_cnt == 4) begin
                q.push_back('{s: 10'(m_acc), a: 8'((m_acc + 2) >> 2), mx: 8'(m_max), mn: 8'(m_min)});
                m_hold = 1;
                m_init();
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0; clr = 0; in_valid = 0; in_data = 0; out_ready = 0;
        m_init(); m_hold = 0; q.delete();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (obs !== '0) begin n_err++; $display("FAIL reset_outputs: got %h want 0", obs); end
        rst_n = 1;
    endtask

    task automatic test_basic();
        byte unsigned s[4] = '{10, 20, 30, 41};
        res_t e;
        foreach (s[i]) drive(1, s[i], 1, 0);
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b want 1", out_valid); end
        e = (q.size() != 0) ? q.pop_front() : 'x;
        n_cmp++; if (obs !== e) begin n_err++; $display("FAIL basic_result: got %h want %h", obs, e); end
        drive(0, 0, 1, 0);
        n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL basic_release: got rdy=%b vld=%b want 1/0", in_ready, out_valid); end
    endtask

    task automatic test_extremes();
        res_t e;
        repeat (4) drive(1, 8'd255, 1, 0);
        e = (q.size() != 0) ? q.pop_front() : 'x;
        n_cmp++; if (out_valid !== 1'b1 || obs !== e) begin n_err++; $display("FAIL ext_max: got vld=%b %h want 1 %h", out_valid, obs, e); end
        drive(1, 8'd200, 1, 0);
        repeat (4) drive(1, 8'd0, 1, 0);
        e = (q.size() != 0) ? q.pop_front() : 'x;
        n_cmp++; if (out_valid !== 1'b1 || obs !== e) begin n_err++; $display("FAIL ext_zero: got vld=%b %h want 1 %h", out_valid, obs, e); end
        drive(0, 0, 1, 0);
    endtask

    task automatic test_stall();
        byte unsigned s[4] = '{5, 6, 7, 8};
        res_t e;
        foreach (s[i]) drive(1, s[i], 0, 0);
        e = (q.size() != 0) ? q[0] : 'x;
        for (int k = 0; k < 5; k++) begin
            drive(1, 'x, 0, 0);
            n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || obs !== e) begin
                n_err++; $display("FAIL stall_hold%0d: got rdy=%b vld=%b %h want 0 1 %h", k, in_ready, out_valid, obs, e);
            end
        end
        drive(1, 8'd99, 1, 0);
        void'(q.pop_front());
        n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL stall_consume: got rdy=%b vld=%b want 1/0", in_ready, out_valid); end
        repeat (4) drive(1, 8'd1, 1, 0);
        e = (q.size() != 0) ? q.pop_front() : 'x;
        n_cmp++; if (out_valid !== 1'b1 || obs !== e) begin n_err++; $display("FAIL stall_next: got vld=%b %h want 1 %h", out_valid, obs, e); end
        drive(0, 0, 1, 0);
    endtask

    task automatic test_clr();
        byte unsigned s[4] = '{1, 2, 3, 4};
        res_t e;
        drive(1, 8'd7, 1, 0);
        drive(1, 8'd9, 1, 0);
        drive(1, 8'd50, 1, 1);
        foreach (s[i]) drive(1, s[i], 1, 0);
        e = (q.size() != 0) ? q.pop_front() : 'x;
        n_cmp++; if (out_valid !== 1'b1 || obs !== e) begin n_err++; $display("FAIL clr_window: got vld=%b %h want 1 %h", out_valid, obs, e); end
        drive(0, 0, 1, 0);
        for (int i = 0; i < 4; i++) drive(1, 8'(100 + i), 0, 0);
        e = (q.size() != 0) ? q.pop_front() : 'x;
        n_cmp++; if (out_valid !== 1'b1 || obs !== e) begin n_err++; $display("FAIL clr_pre_hold: got vld=%b %h want 1 %h", out_valid, obs, e); end
        drive(0, 0, 0, 1);
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || obs !== e) begin
            n_err++; $display("FAIL clr_in_hold: got vld=%b rdy=%b %h want 0 1 %h", out_valid, in_ready, obs, e);
        end
    endtask

    task automatic test_async_reset();
        byte unsigned s[4] = '{2, 2, 2, 3};
        res_t e;
        for (int i = 0; i < 4; i++) drive(1, 8'(60 + i), 0, 0);
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL arst_pre: got %b want 1", out_valid); end
        @(negedge clk);
        rst_n = 0;
        m_init(); m_hold = 0; q.delete();
        #1;
        n_cmp++; if (out_valid !== 1'b0 || obs !== '0) begin n_err++; $display("FAIL arst_immediate: got vld=%b %h want 0 0", out_valid, obs); end
        @(posedge clk);
        #1;
        rst_n = 1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL arst_ready: got %b want 1", in_ready); end
        foreach (s[i]) drive(1, s[i], 1, 0);
        e = (q.size() != 0) ? q.pop_front() : 'x;
        n_cmp++; if (out_valid !== 1'b1 || obs !== e) begin n_err++; $display("FAIL arst_window: got vld=%b %h want 1 %h", out_valid, obs, e); end
        drive(0, 0, 1, 0);
    endtask

    task automatic test_back_to_back();
        int   nres = 0;
        res_t e;
        drive(0, 0, 1, 0);
        for (int i = 0; i < 20; i++) begin
            drive(1, 8'(i), 1, 0);
            n_cmp++; if (out_valid !== ((i % 5) == 3)) begin n_err++; $display("FAIL b2b_valid%0d: got %b want %b", i, out_valid, (i % 5) == 3); end
            if (out_valid === 1'b1) begin
                nres++;
                e = (q.size() != 0) ? q.pop_front() : 'x;
                n_cmp++; if (obs !== e) begin n_err++; $display("FAIL b2b_result%0d: got %h want %h", i, obs, e); end
            end
        end
        n_cmp++; if (nres != 4) begin n_err++; $display("FAIL b2b_count: got %0d want 4", nres); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_stall();
        test_clr();
        test_async_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
